// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with start-glitch rejection, framing-error and break handling
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ttl_rx_i,
  output logic [7:0] rx_data,
  output logic       recv_flag,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state, state_nx;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic rx_s, tick_half, tick_full, stop_ok, stop_bad;
  assign rx_s = sync[1];
  assign tick_half = cnt == HALF;
  assign tick_full = cnt == FULL;
  assign stop_ok = state == STOP && tick_full && rx_s;
  assign stop_bad = state == STOP && tick_full && !rx_s;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = rx_s ? IDLE : START;
      START:   state_nx = !tick_half ? START : rx_s ? IDLE : DATA;
      DATA:    state_nx = tick_full && bit_idx == 3'd7 ? STOP : DATA;
      STOP:    state_nx = !tick_full ? STOP : rx_s ? IDLE : BRK;
      BRK:     state_nx = rx_s ? IDLE : BRK;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= 2'b11;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      recv_flag <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[0], ttl_rx_i};
      state     <= state_nx;
      cnt       <= (state_nx != state || tick_full || state inside {IDLE, BRK}) ? '0 : cnt + 1'b1;
      bit_idx   <= state == DATA ? (tick_full ? bit_idx + 1'b1 : bit_idx) : '0;
      shift     <= state == DATA && tick_full ? {rx_s, shift[7:1]} : shift;
      rx_data   <= stop_ok ? shift : rx_data;
      recv_flag <= stop_ok;
      frame_err <= stop_bad;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven and randomized self-checking bench for uart_rx
module tb_uart_rx;
  localparam int CPB = 8;
  localparam int LAT = CPB / 2 + 9 * CPB + 1 + 2;
  typedef struct {
    logic       err;
    logic [7:0] data;
    int         cyc;
  } ev_t;
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ttl_rx_i = 1'b1;
  logic [7:0] rx_data;
  logic recv_flag, frame_err, busy;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  logic both_seen = 1'b0;
  ev_t obs_q[$];
  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .ttl_rx_i(ttl_rx_i),
    .rx_data(rx_data),
    .recv_flag(recv_flag),
    .frame_err(frame_err),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (recv_flag || frame_err) obs_q.push_back('{frame_err, rx_data, cyc});
    if (recv_flag && frame_err) both_seen = 1'b1;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop, input int hold, output int start);
    start = cyc;
    ttl_rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ttl_rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    ttl_rx_i = stop;
    repeat (CPB) @(negedge clk);
    if (!stop) begin
      repeat (hold) @(negedge clk);
      ttl_rx_i = 1'b1;
      repeat (CPB) @(negedge clk);
    end
  endtask
  task automatic check_event(input string name, input logic exp_err, input logic [7:0] exp_data, input int start);
    ev_t ev;
    check({name, " count"}, obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      ev = obs_q.pop_front();
      check({name, " kind"}, ev.err, exp_err);
      check({name, " data"}, ev.data, exp_data);
      check({name, " latency"}, ev.cyc - start, LAT);
    end
    obs_q.delete();
  endtask
  initial begin
    vec_t vecs[6];
    int start;
    logic [7:0] last_good;
    logic saw_busy;
    vecs[0] = '{8'hA5, 1'b1, 0, 1'b0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 0, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 0, 1'b0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b1, 0, 1'b0, 8'h3C};
    vecs[4] = '{8'h55, 1'b0, 40, 1'b1, 8'h3C};
    vecs[5] = '{8'h12, 1'b1, 0, 1'b0, 8'h12};
    repeat (3) @(negedge clk);
    check("reset rx_data", rx_data, 8'h00);
    check("reset recv_flag", recv_flag, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    check("reset busy", busy, 1'b0);
    rst = 1'b0;
    obs_q.delete();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].hold, start);
      check_event($sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_data, start);
    end
    last_good = 8'h12;
    repeat (4) @(negedge clk);
    ttl_rx_i = 1'b0;
    repeat (2) @(negedge clk);
    ttl_rx_i = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      saw_busy |= busy;
      @(negedge clk);
    end
    check("glitch busy pulse", saw_busy, 1'b1);
    check("glitch busy end", busy, 1'b0);
    check("glitch no flags", obs_q.size(), 0);
    check("glitch rx_data", rx_data, last_good);
    ttl_rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ttl_rx_i = (8'hC3 >> i) & 8'h01;
      repeat (CPB) @(negedge clk);
    end
    ttl_rx_i = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst busy", busy, 1'b0);
    check("midrst rx_data", rx_data, 8'h00);
    repeat (10) @(negedge clk);
    check("midrst no flags", obs_q.size(), 0);
    obs_q.delete();
    send_frame(8'h81, 1'b1, 0, start);
    check_event("after rst", 1'b0, 8'h81, start);
    last_good = 8'h81;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] b;
      logic stop;
      b = 8'($urandom);
      stop = $urandom_range(4) != 0;
      send_frame(b, stop, int'($urandom_range(20)), start);
      check_event($sformatf("rand%0d", i), !stop, stop ? b : last_good, start);
      if (stop) last_good = b;
      repeat ($urandom_range(10)) @(negedge clk);
    end
    check("flags never together", both_seen, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
